bdd_seq_evaluator: RTL

- Runtime-loadable, sequential BDD evaluator; parametrised successor to the fixed combinational per-output-bit BDD modules.
- Holds a node table and NUM_OUT root pointers; walks one node per clock per output over a captured IN_W-bit input vector; returns an NUM_OUT-bit result.
- Sits beside the CPU-cluster predictor so output functions can be reloaded without resynthesis.
- Valid/ready on both input and output, with a config write port.

---
 rtl/bdd_eval_pkg.sv | 59 +++++
 rtl/bdd_node_table.sv | 28 ++
 rtl/bdd_seq_evaluator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bdd_eval_pkg.sv
// bdd_eval_pkg: shared state enum, pointer bit positions, width helpers and
// the packed node word for the sequential BDD evaluator.
// Optional feature macro: BDD_COMPLEMENT_EDGE_EN (adds an invert bit above the
// terminal flag in every child and root pointer).
package bdd_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the variable index field of a node word.
  function automatic int calc_var_w(input int in_w);
    return (in_w > 1) ? $clog2(in_w) : 1;
  endfunction

  // Width of a node index.
  function automatic int calc_node_aw(input int nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

  // Child pointer: node index, terminal flag above it, optional invert bit on top.
  function automatic int calc_child_w(input int nodes);
`ifdef BDD_COMPLEMENT_EDGE_EN
    return calc_node_aw(nodes) + 2;
`else
    return calc_node_aw(nodes) + 1;
`endif
  endfunction

  // Node word {var, lo, hi}.
  function automatic int calc_node_w(input int in_w, input int nodes);
    return calc_var_w(in_w) + 2 * calc_child_w(nodes);
  endfunction

  // Position of the terminal flag inside a child pointer.
  function automatic int term_bit(input int nodes);
    return calc_node_aw(nodes);
  endfunction

  // Position of the invert flag inside a child pointer (complement-edge build).
  function automatic int inv_bit(input int nodes);
    return calc_node_aw(nodes) + 1;
  endfunction

  localparam int DEF_IN_W    = 1894;
  localparam int DEF_NODES   = 256;
  localparam int DEF_VAR_W   = calc_var_w(DEF_IN_W);
  localparam int DEF_CHILD_W = calc_child_w(DEF_NODES);

  // Node word layout for the default geometry; var sits in the MSBs.
  typedef struct packed {
    logic [DEF_VAR_W-1:0]   var_idx;
    logic [DEF_CHILD_W-1:0] lo;
    logic [DEF_CHILD_W-1:0] hi;
  } node_t;

endpackage

// File: rtl/bdd_node_table.sv
// bdd_node_table: NODES x NODE_W register array with one write port and one
// asynchronous read port, so the walk can take one node per clock.
// Contents are intentionally not reset; only configuration writes define them.
module bdd_node_table #(
  parameter int NODES  = 256,
  parameter int NODE_W = 29,
  localparam int AW    = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [NODE_W-1:0] rdata
);

  logic [NODE_W-1:0] mem_r [NODES];

  // Store configuration writes; the table has no reset by design.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/bdd_seq_evaluator.sv
// bdd_seq_evaluator: runtime-loadable sequential BDD evaluator. Walks one node
// per clock for each of NUM_OUT roots over a captured input vector.
// Optional feature macro: BDD_COMPLEMENT_EDGE_EN (complement edges + parity).
module bdd_seq_evaluator
  import bdd_eval_pkg::*;
#(
  parameter int IN_W      = 1894,
  parameter int NUM_OUT   = 8,
  parameter int NODES     = 256,
  parameter int MAX_DEPTH = 64,
  localparam int VAR_W    = calc_var_w(IN_W),
  localparam int NODE_AW  = calc_node_aw(NODES),
  localparam int CHILD_W  = calc_child_w(NODES),
  localparam int NODE_W   = calc_node_w(IN_W, NODES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    i,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [NUM_OUT-1:0] o,
  output logic [NUM_OUT-1:0] o_err,
  output logic               o_valid,
  input  logic               o_ready,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [NODE_W-1:0]  cfg_wdata
);

  localparam int KW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int TB = term_bit(NODES);
  localparam logic [CHILD_W-1:0] ROOT_T0 = CHILD_W'(1) << TB;

  state_t             state_r;
  logic               i_ready_r;
  logic               o_valid_r;
  logic [NUM_OUT-1:0] o_r;
  logic [NUM_OUT-1:0] o_err_r;
  logic [IN_W-1:0]    in_r;
  logic [KW-1:0]      k_r;
  logic [CHILD_W-1:0] ptr_r;
  logic [DW-1:0]      depth_r;
  logic [CHILD_W-1:0] root_r [NUM_OUT];

  logic [NODE_W-1:0]  node_s;
  logic [VAR_W-1:0]   var_s;
  logic [CHILD_W-1:0] lo_s;
  logic [CHILD_W-1:0] hi_s;
  logic               sel_bit_s;
  logic [CHILD_W-1:0] next_ptr_s;
  logic [CHILD_W-1:0] root0_s;
  logic [KW-1:0]      k_next_s;
  logic               cfg_ok_s;
  logic               node_we_s;
  logic               root_we_s;
  logic               accept_s;
  logic               is_term_s;
  logic               abort_s;
  logic               advance_s;
  logic               step_s;
  logic               last_s;
  logic               term_val_s;

  bdd_node_table #(
    .NODES  (NODES),
    .NODE_W (NODE_W)
  ) u_table (
    .clk   (clk),
    .we    (node_we_s),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (ptr_r[NODE_AW-1:0]),
    .rdata (node_s)
  );

  assign var_s = node_s[NODE_W-1 -: VAR_W];
  assign lo_s  = node_s[2*CHILD_W-1 -: CHILD_W];
  assign hi_s  = node_s[CHILD_W-1:0];

  // Config is only honoured in IDLE; i_ready_r is high exactly there.
  assign cfg_ok_s  = cfg_we & i_ready_r;
  assign node_we_s = cfg_ok_s & ~cfg_sel;
  assign root_we_s = cfg_ok_s & cfg_sel & (int'(cfg_addr) < NUM_OUT);

  assign accept_s  = i_valid & i_ready_r;
  assign is_term_s = ptr_r[TB];
  assign abort_s   = ~is_term_s & (depth_r == DW'(MAX_DEPTH));
  assign advance_s = (state_r == WALK) & (is_term_s | abort_s);
  assign step_s    = (state_r == WALK) & ~is_term_s & ~abort_s;
  assign last_s    = (k_r == KW'(NUM_OUT - 1));
  assign k_next_s  = k_r + KW'(1);

  // Edge selection and same-cycle root-0 write bypass for the accept.
  always_comb begin
    sel_bit_s  = 1'b0;
    next_ptr_s = lo_s;
    root0_s    = root_r[0];
    if (int'(var_s) < IN_W) begin
      sel_bit_s = in_r[var_s];
    end else begin
      sel_bit_s = 1'b0;
    end
    if (sel_bit_s) begin
      next_ptr_s = hi_s;
    end else begin
      next_ptr_s = lo_s;
    end
    if (root_we_s && (cfg_addr == NODE_AW'(0))) begin
      root0_s = cfg_wdata[CHILD_W-1:0];
    end else begin
      root0_s = root_r[0];
    end
  end

`ifdef BDD_COMPLEMENT_EDGE_EN
  localparam int IB = inv_bit(NODES);
  logic parity_r;

  assign term_val_s = ptr_r[0] ^ parity_r;

  // Parity of invert bits along the current path, restarted at each root load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (accept_s) begin
      parity_r <= root0_s[IB];
    end else if (advance_s && !last_s) begin
      parity_r <= root_r[k_next_s][IB];
    end else if (step_s) begin
      parity_r <= parity_r ^ next_ptr_s[IB];
    end else begin
      parity_r <= parity_r;
    end
  end
`else
  assign term_val_s = ptr_r[0];
`endif

  // Root pointer registers: reset to terminal 0, written by config in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_OUT; n++) begin
        root_r[n] <= ROOT_T0;
      end
    end else if (root_we_s) begin
      root_r[cfg_addr[KW-1:0]] <= cfg_wdata[CHILD_W-1:0];
    end
  end

  // Evaluation FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      i_ready_r <= 1'b1;
      o_valid_r <= 1'b0;
      o_r       <= '0;
      o_err_r   <= '0;
      in_r      <= '0;
      k_r       <= '0;
      ptr_r     <= '0;
      depth_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_r      <= i;
            o_r       <= '0;
            o_err_r   <= '0;
            k_r       <= '0;
            ptr_r     <= root0_s;
            depth_r   <= '0;
            i_ready_r <= 1'b0;
            state_r   <= WALK;
          end
        end
        WALK: begin
          if (advance_s) begin
            o_r[k_r]     <= is_term_s ? term_val_s : 1'b0;
            o_err_r[k_r] <= ~is_term_s;
            if (last_s) begin
              o_valid_r <= 1'b1;
              state_r   <= DONE;
            end else begin
              k_r     <= k_next_s;
              ptr_r   <= root_r[k_next_s];
              depth_r <= '0;
            end
          end else begin
            ptr_r   <= next_ptr_s;
            depth_r <= depth_r + DW'(1);
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid_r <= 1'b0;
            i_ready_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          o_valid_r <= 1'b0;
          i_ready_r <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign i_ready = i_ready_r;
  assign o       = o_r;
  assign o_err   = o_err_r;
  assign o_valid = o_valid_r;

endmodule
